// File: rtl/paralelo_serial_lanes_pkg.sv
// Shared constants for the parallel-to-serial transmitter and its matching
// serial-to-parallel receiver: the idle comma symbol and the default
// word width, lane count and input buffer depth.
package paralelo_serial_lanes_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_LANES      = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  // K28.5 comma, sent whenever there is nothing queued.
  localparam logic [7:0] K28_5        = 8'hBC;
  localparam logic [7:0] DEF_IDLE_SYM = K28_5;

  // Width of a counter that runs 0..bpl-1; kept at least one bit wide so
  // the single-step-per-word case still has a legal vector.
  function automatic int step_w(input int bpl);
    return (bpl > 1) ? $clog2(bpl) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO buffering parallel words ahead of the serialiser.
// Ports:
//   clk_4f  - clock, rising edge
//   reset   - synchronous, active-low; empties the FIFO
//   push    - write din (ignored when full)
//   pop     - drop the head word (ignored when empty)
//   din     - word to write
//   dout    - current head word (valid while !empty)
//   full    - count == DEPTH
//   empty   - count == 0
//   count   - current occupancy, 0..DEPTH
module fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; pointers and
  // count define which entries are live, so stale contents are never read.
  always_ff @(posedge clk_4f) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of 2, so the pointers wrap modulo DEPTH for free.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/paralelo_serial_lanes.sv
// Parallel-to-serial transmitter over LANES serial lanes.
// Words are buffered in a FIFO; each word occupies BPL = DATA_W/LANES
// consecutive cycles, lane k sending its own slice W[k*BPL +: BPL]
// MSB-first. When the FIFO is empty at a word boundary IDLE_SYM is sent.
// Ports:
//   clk_4f     - clock, rising edge
//   reset      - synchronous, active-low
//   data_in    - parallel word from upstream
//   valid_in   - data_in qualifier; accepted when ready_out is high
//   ready_out  - FIFO not full (low during reset)
//   data_out   - one registered serial bit per lane
//   word_start - registered, high while data_out carries a word's first bit
//   idle_out   - registered, high while data_out carries IDLE_SYM bits
//   fifo_count - FIFO occupancy
module paralelo_serial_lanes
  import paralelo_serial_lanes_pkg::*;
#(
  parameter  int                DATA_W     = DEF_DATA_W,
  parameter  int                LANES      = DEF_LANES,
  parameter  int                FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(DEF_IDLE_SYM),
  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LANES-1:0]  data_out,
  output logic              word_start,
  output logic              idle_out,
  output logic [CNT_W-1:0]  fifo_count
);

  if (DATA_W % LANES != 0) begin : g_bad_lanes
    $error("paralelo_serial_lanes: DATA_W must be a multiple of LANES");
  end

  localparam int BPL    = DATA_W / LANES;
  localparam int STEP_W = step_w(BPL);

  logic [STEP_W-1:0] step;
  logic              step0;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] cur_word;
  logic              idle_q;
  logic              cur_idle;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [LANES-1:0]  lane_bits;

  assign step0     = (step == '0);
  assign ready_out = reset && !fifo_full;
  assign push      = valid_in && ready_out;
  assign pop       = reset && step0 && !fifo_empty;

  fifo_sync #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_4f (clk_4f),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (data_in),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Word being serialised this cycle: freshly selected on a step-0 cycle,
  // otherwise the word latched at the last boundary.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    cur_word = word_q;
    cur_idle = idle_q;
    if (step0) begin
      if (fifo_empty) begin
        cur_word = IDLE_SYM;
        cur_idle = 1'b1;
      end else begin
        cur_word = fifo_head;
        cur_idle = 1'b0;
      end
    end
  end

  // Lane k's slice is reversed so that index `step` picks the MSB-first bit.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [BPL-1:0] slice_rev;
    for (genvar i = 0; i < BPL; i++) begin : g_bit
      assign slice_rev[i] = cur_word[k*BPL + BPL-1-i];
    end
    assign lane_bits[k] = slice_rev[step];
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      step       <= '0;
      word_q     <= '0;
      idle_q     <= 1'b0;
      data_out   <= '0;
      word_start <= 1'b0;
      idle_out   <= 1'b0;
    end else begin
      step       <= (step == STEP_W'(BPL-1)) ? '0 : step + 1'b1;
      word_q     <= cur_word;
      idle_q     <= cur_idle;
      data_out   <= lane_bits;
      word_start <= step0;
      idle_out   <= cur_idle;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_lanes.sv
// Bench for paralelo_serial_lanes: three instances (LANES = 1, 2, 8; DATA_W 8,
// FIFO_DEPTH 4) share clock and reset. A queue-style model predicts every
// output each cycle; directed phases pin the model with literal values.
module tb_paralelo_serial_lanes;

  localparam int         DEPTH = 4;
  localparam int         MBUF  = 8192;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [2:0] valid;
  logic [7:0] din [3];
  logic [2:0] rdy, ws, idl;
  logic [0:0] do1;
  logic [1:0] do2;
  logic [7:0] do8;
  logic [2:0] cnt0, cnt1, cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_4f = ~clk_4f;

  paralelo_serial_lanes #(.DATA_W(8), .LANES(1), .FIFO_DEPTH(DEPTH), .IDLE_SYM(IDLE)) u_l1 (
    .clk_4f(clk_4f), .reset(reset), .data_in(din[0]), .valid_in(valid[0]), .ready_out(rdy[0]),
    .data_out(do1), .word_start(ws[0]), .idle_out(idl[0]), .fifo_count(cnt0));

  paralelo_serial_lanes #(.DATA_W(8), .LANES(2), .FIFO_DEPTH(DEPTH), .IDLE_SYM(IDLE)) u_l2 (
    .clk_4f(clk_4f), .reset(reset), .data_in(din[1]), .valid_in(valid[1]), .ready_out(rdy[1]),
    .data_out(do2), .word_start(ws[1]), .idle_out(idl[1]), .fifo_count(cnt1));

  paralelo_serial_lanes #(.DATA_W(8), .LANES(8), .FIFO_DEPTH(DEPTH), .IDLE_SYM(IDLE)) u_l8 (
    .clk_4f(clk_4f), .reset(reset), .data_in(din[2]), .valid_in(valid[2]), .ready_out(rdy[2]),
    .data_out(do8), .word_start(ws[2]), .idle_out(idl[2]), .fifo_count(cnt2));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pushed words live in a never-wrapping array; wr/rd are running totals.
  logic [7:0] mbuf [3][MBUF];
  int         wr [3];
  int         rd [3];
  int         pos [3];
  logic [7:0] curw [3];
  logic       cidle [3];
  logic [7:0] exp_d [3];
  logic       exp_s [3];
  logic       exp_i [3];
  logic       exp_r [3];
  int         exp_c [3];
  logic       pushed [3];
  logic       model_live = 1'b0;

  function automatic int bpl_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 4 : 1;
  endfunction

  // Applies one rising edge to the model using the inputs presented to it.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int b;
      int occ;
      b = bpl_of(i);
      occ = wr[i] - rd[i];
      pushed[i] = 1'b0;
      if (!reset) begin
        rd[i]    = wr[i];
        pos[i]   = 0;
        exp_d[i] = '0;
        exp_s[i] = 1'b0;
        exp_i[i] = 1'b0;
      end else begin
        if (pos[i] == 0) begin
          if (occ > 0) begin
            curw[i]  = mbuf[i][rd[i] % MBUF];
            rd[i]++;
            cidle[i] = 1'b0;
          end else begin
            curw[i]  = IDLE;
            cidle[i] = 1'b1;
          end
        end
        if (valid[i] && occ < DEPTH) begin
          mbuf[i][wr[i] % MBUF] = din[i];
          wr[i]++;
          pushed[i] = 1'b1;
        end
        exp_d[i] = '0;
        for (int k = 0; k < 8 / b; k++) exp_d[i][k] = curw[i][k*b + b-1-pos[i]];
        exp_s[i] = (pos[i] == 0);
        exp_i[i] = cidle[i];
        pos[i]   = (pos[i] + 1) % b;
      end
      exp_c[i] = wr[i] - rd[i];
      exp_r[i] = reset && (exp_c[i] < DEPTH);
    end
    model_live = 1'b1;
  endtask

  // ---------------- compare process ----------------
  logic [7:0] act_d [3];
  logic [2:0] act_c [3];

  always @(negedge clk_4f) begin
    if (model_live) begin
      act_d[0] = {7'b0, do1};
      act_d[1] = {6'b0, do2};
      act_d[2] = do8;
      act_c[0] = cnt0;
      act_c[1] = cnt1;
      act_c[2] = cnt2;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("inst%0d data_out", i),   32'(act_d[i]), 32'(exp_d[i]));
        check($sformatf("inst%0d word_start", i), 32'(ws[i]),    32'(exp_s[i]));
        check($sformatf("inst%0d idle_out", i),   32'(idl[i]),   32'(exp_i[i]));
        check($sformatf("inst%0d ready_out", i),  32'(rdy[i]),   32'(exp_r[i]));
        check($sformatf("inst%0d fifo_count", i), 32'(act_c[i]), 32'(exp_c[i]));
      end
    end
  end

  // Inputs change just after the falling edge, clear of both sampling points.
  task automatic step_cycle();
    @(posedge clk_4f);
    model_edge();
    @(negedge clk_4f);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] g0_d, g0_s, g0_i, g1_d, g16_d, g16_i;
  logic [23:0] g2_d;
  logic [2:0]  g2_i;
  logic [7:0]  sent;
  int          n_acc, max_cnt, found;

  initial begin
    reset = 1'b0;
    valid = '0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; wr[i] = 0; rd[i] = 0; pos[i] = 0;
      curw[i] = IDLE; cidle[i] = 1'b1; pushed[i] = 1'b0;
    end

    // Reset state.
    repeat (3) step_cycle();
    check("reset ready_out", 32'(rdy), 32'(0));
    check("reset data_out lanes8", 32'(do8), 32'(0));
    check("reset fifo_count", 32'(cnt1), 32'(0));

    // Release reset and push one word into every instance on the first edge.
    reset = 1'b1;
    valid = 3'b111;
    din[0] = 8'hA5; din[1] = 8'h3C; din[2] = 8'h11;
    step_cycle();
    valid = '0;
    for (int c = 0; c < 16; c++) begin
      g0_d[15-c] = do1[0];
      g0_s[15-c] = ws[0];
      g0_i[15-c] = idl[0];
      if (c < 8) g1_d[15-2*c -: 2] = do2;
      if (c < 3) begin
        g2_d[23-8*c -: 8] = do8;
        g2_i[2-c] = idl[2];
      end
      step_cycle();
    end
    check("lanes1 bits BC then A5", 32'(g0_d), 32'(16'hBCA5));
    check("lanes1 word_start", 32'(g0_s), 32'(16'h8080));
    check("lanes1 idle_out", 32'(g0_i), 32'(16'hFF00));
    check("lanes2 idle then 3C", 32'(g1_d), 32'(16'hDA5A));
    check("lanes8 idle, word, idle", 32'(g2_d), 32'(24'hBC11BC));
    check("lanes8 idle_out", 32'(g2_i), 32'(3'b101));

    // Six back-to-back words into the LANES=1 instance.
    n_acc = 0; max_cnt = 0;
    valid[0] = 1'b1; din[0] = 8'h60;
    for (int c = 0; c < 100 && n_acc < 6; c++) begin
      step_cycle();
      if (pushed[0]) begin
        n_acc++;
        din[0] = 8'(8'h60 + n_acc);
        if (n_acc == 4) begin
          check("ready_out after 4th push", 32'(rdy[0]), 32'(0));
          check("fifo_count at full", 32'(cnt0), 32'(4));
        end
      end
      if (int'(cnt0) > max_cnt) max_cnt = int'(cnt0);
    end
    valid[0] = 1'b0;
    check("six words accepted", 32'(n_acc), 32'(6));
    check("fifo_count peak", 32'(max_cnt), 32'(4));
    repeat (50) step_cycle();

    // LANES=8: continuous incrementing words, one per cycle.
    valid[2] = 1'b1; din[2] = 8'h00;
    for (int c = 0; c < 40; c++) begin
      sent = din[2];
      step_cycle();
      din[2] = sent + 8'd1;
      check("lanes8 ready_out steady", 32'(rdy[2]), 32'(1));
      if (c > 0) check("lanes8 word one cycle later", 32'(do8), 32'(8'(sent - 8'd1)));
    end
    valid[2] = 1'b0;
    repeat (4) step_cycle();

    // Reset in the middle of a word with two words still queued.
    n_acc = 0;
    valid[0] = 1'b1; din[0] = 8'h71;
    for (int c = 0; c < 50 && n_acc < 3; c++) begin
      step_cycle();
      if (pushed[0]) begin
        n_acc++;
        din[0] = 8'(8'h71 + n_acc);
      end
    end
    valid[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (pos[0] == 4 && (wr[0] - rd[0]) == 2) found = 1;
      else step_cycle();
    end
    check("reached step 3 with 2 queued", 32'(found), 32'(1));
    reset = 1'b0;
    step_cycle();
    check("mid-word reset data_out", 32'(do1), 32'(0));
    check("mid-word reset fifo_count", 32'(cnt0), 32'(0));
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step_cycle();
      g16_d[15-c] = do1[0];
      g16_i[15-c] = idl[0];
    end
    check("post-reset idle bits", 32'(g16_d), 32'(16'hBCBC));
    check("post-reset idle_out", 32'(g16_i), 32'(16'hFFFF));

    // Randomised traffic with occasional resets; crosses pointer wrap often.
    for (int c = 0; c < 1500; c++) begin
      valid[0] = ($urandom_range(0, 7) == 0);
      valid[1] = ($urandom_range(0, 2) == 0);
      valid[2] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) din[i] = 8'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      step_cycle();
    end
    reset = 1'b1;
    valid = '0;
    repeat (20) step_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
